mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset controller with memory handshake
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   OpCode, Funct     instruction fields from the datapath IR
//   Zero              ALU zero flag (beq resolution)
//   mem_ready         memory completes the current request this cycle
//   mem_req, MemRead, MemWrite       memory request and access type
//   PCWrite, IRWrite, RegWrite, ALUSrc, RegDst, DataSrc, NPC_Sel, ExtOp, ALUOp
//                     datapath enables and selects
//   illegal           one-cycle pulse when an undecodable instruction is decoded
//   retired           retired-instruction counter (wraps)
//   state             current FSM state, for debug

module mc_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          OpCode,
    input  logic [5:0]          Funct,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic [1:0]          RegDst,
    output logic [1:0]          DataSrc,
    output logic [1:0]          NPC_Sel,
    output logic [1:0]          ExtOp,
    output logic [2:0]          ALUOp,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    state_t             state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    instr_t             instr;

    // Instruction decode straight from the IR fields.
    always_comb begin
        instr = I_ILL;
        case (OpCode)
            6'b000000: begin
                case (Funct)
                    6'b100001: instr = I_ADDU;
                    6'b100011: instr = I_SUBU;
                    6'b001000: instr = I_JR;
                    default:   instr = I_ILL;
                endcase
            end
            6'b001101: instr = I_ORI;
            6'b001111: instr = I_LUI;
            6'b100011: instr = I_LW;
            6'b101011: instr = I_SW;
            6'b000100: instr = I_BEQ;
            6'b000010: instr = I_J;
            6'b000011: instr = I_JAL;
            default:   instr = I_ILL;
        endcase
    end

    // Control outputs and next state. Everything is held at zero while reset
    // is asserted, so the FETCH request only starts once reset is released.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegDst   = 2'b00;
        DataSrc  = 2'b00;
        NPC_Sel  = 2'b00;
        ExtOp    = 2'b00;
        ALUOp    = 3'b000;
        illegal  = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = S_EXEC;
                    case (instr)
                        I_J: begin
                            PCWrite = 1'b1;
                            NPC_Sel = 2'b10;
                            state_d = S_FETCH;
                        end
                        I_JAL: begin
                            PCWrite  = 1'b1;
                            NPC_Sel  = 2'b10;
                            RegWrite = 1'b1;
                            RegDst   = 2'b10;
                            DataSrc  = 2'b10;
                            state_d  = S_FETCH;
                        end
                        I_JR: begin
                            PCWrite = 1'b1;
                            NPC_Sel = 2'b11;
                            state_d = S_FETCH;
                        end
                        I_ILL: begin
                            // Skip the bad instruction: advance PC, flag it.
                            illegal = 1'b1;
                            PCWrite = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    state_d = S_WB;
                    case (instr)
                        I_SUBU: ALUOp = 3'b001;
                        I_ORI: begin
                            ALUOp  = 3'b010;
                            ALUSrc = 1'b1;
                        end
                        I_LUI: begin
                            ALUOp  = 3'b010;
                            ALUSrc = 1'b1;
                            ExtOp  = 2'b10;
                        end
                        I_LW, I_SW: begin
                            ALUSrc  = 1'b1;
                            ExtOp   = 2'b01;
                            state_d = S_MEM;
                        end
                        I_BEQ: begin
                            ALUOp   = 3'b001;
                            ExtOp   = 2'b01;
                            PCWrite = 1'b1;
                            NPC_Sel = Zero ? 2'b01 : 2'b00;
                            state_d = S_FETCH;
                        end
                        default: ALUOp = 3'b000;
                    endcase
                end
                S_MEM: begin
                    // ALU keeps driving the address from EXEC operands.
                    mem_req = 1'b1;
                    ALUSrc  = 1'b1;
                    ExtOp   = 2'b01;
                    if (instr == I_SW) begin
                        MemWrite = 1'b1;
                        if (mem_ready) begin
                            PCWrite = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        MemRead = 1'b1;
                        if (mem_ready) state_d = S_WB;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    if (instr == I_ADDU || instr == I_SUBU) RegDst = 2'b01;
                    if (instr == I_LW) DataSrc = 2'b01;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (PCWrite && !illegal) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with per-instruction reference traces

module tb_mc_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    OpCode = '0;
    logic [5:0]    Funct = '0;
    logic          Zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, MemRead, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrc;
    logic [1:0]    RegDst, DataSrc, NPC_Sel, ExtOp;
    logic [2:0]    ALUOp;
    logic          illegal;
    logic [RW-1:0] retired;
    logic [2:0]    state;

    mc_ctrl #(.RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .RegDst(RegDst), .DataSrc(DataSrc),
        .NPC_Sel(NPC_Sel), .ExtOp(ExtOp), .ALUOp(ALUOp), .illegal(illegal),
        .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
    } kind_e;

    typedef struct packed {
        logic [2:0] st;
        logic       mreq, mrd, mwr, pcw, irw, regw, alusrc;
        logic [1:0] regdst, datasrc, npc, extop;
        logic [2:0] aluop;
        logic       ill;
    } sig_t;

    typedef struct packed {
        logic          mr;
        logic          z;
        logic [RW-1:0] ret;
        sig_t          sig;
    } step_t;

    step_t    scb[$];
    step_t    trace[$];
    int       n_checks = 0;
    int       n_pass = 0;
    bit       mon_en = 1'b0;
    int       model_ret = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    endtask

    function automatic sig_t dut_sig();
        sig_t s;
        s = '{st: state, mreq: mem_req, mrd: MemRead, mwr: MemWrite, pcw: PCWrite,
              irw: IRWrite, regw: RegWrite, alusrc: ALUSrc, regdst: RegDst,
              datasrc: DataSrc, npc: NPC_Sel, extop: ExtOp, aluop: ALUOp, ill: illegal};
        return s;
    endfunction

    // Monitor: every cycle the DUT presents one set of outputs; compare it
    // against the next expected step.
    always @(negedge clk) begin
        if (mon_en && scb.size() > 0) begin
            step_t e;
            sig_t  gsig;
            e = scb.pop_front();
            gsig = dut_sig();
            check("cycle_outputs", 64'(gsig), 64'(e.sig));
            check("retired", 64'(retired), 64'(e.ret));
            if (MemWrite && RegWrite) check("memwrite_regwrite_exclusive", 64'd1, 64'd0);
        end
    end

    // Appends one expected cycle; the model counter advances on retirement.
    task automatic push_step(input step_t s);
        s.ret = RW'(model_ret);
        trace.push_back(s);
        if (s.sig.pcw && !s.sig.ill) model_ret = (model_ret + 1) % (1 << RW);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction.
    task automatic build(input kind_e k, input int fw, input int mw, input logic z);
        step_t s;
        for (int i = 0; i < fw; i++) begin
            s = '0; s.sig.mreq = 1; s.sig.mrd = 1; s.z = 1'($urandom);
            push_step(s);
        end
        s = '0; s.sig.mreq = 1; s.sig.mrd = 1; s.sig.irw = 1; s.mr = 1; s.z = 1'($urandom);
        push_step(s);

        s = '0; s.sig.st = 3'd1; s.mr = 1'($urandom); s.z = 1'($urandom);
        case (k)
            K_J:   begin s.sig.pcw = 1; s.sig.npc = 2'b10; end
            K_JAL: begin s.sig.pcw = 1; s.sig.npc = 2'b10; s.sig.regw = 1;
                         s.sig.regdst = 2'b10; s.sig.datasrc = 2'b10; end
            K_JR:  begin s.sig.pcw = 1; s.sig.npc = 2'b11; end
            K_ILL: begin s.sig.pcw = 1; s.sig.ill = 1; end
            default: ;
        endcase
        push_step(s);
        if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;

        s = '0; s.sig.st = 3'd2; s.mr = 1'($urandom); s.z = 1'($urandom);
        case (k)
            K_SUBU: s.sig.aluop = 3'b001;
            K_ORI:  begin s.sig.aluop = 3'b010; s.sig.alusrc = 1; end
            K_LUI:  begin s.sig.aluop = 3'b010; s.sig.alusrc = 1; s.sig.extop = 2'b10; end
            K_LW, K_SW: begin s.sig.alusrc = 1; s.sig.extop = 2'b01; end
            K_BEQ:  begin s.sig.aluop = 3'b001; s.sig.extop = 2'b01; s.sig.pcw = 1;
                          s.z = z; s.sig.npc = z ? 2'b01 : 2'b00; end
            default: ;
        endcase
        push_step(s);
        if (k == K_BEQ) return;

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mw; i++) begin
                s = '0; s.sig.st = 3'd3; s.sig.mreq = 1; s.sig.alusrc = 1; s.sig.extop = 2'b01;
                s.z = 1'($urandom);
                if (k == K_LW) s.sig.mrd = 1; else s.sig.mwr = 1;
                s.mr = (i == mw);
                if (i == mw && k == K_SW) s.sig.pcw = 1;
                push_step(s);
            end
            if (k == K_SW) return;
        end

        s = '0; s.sig.st = 3'd4; s.sig.regw = 1; s.sig.pcw = 1;
        s.mr = 1'($urandom); s.z = 1'($urandom);
        if (k == K_ADDU || k == K_SUBU) s.sig.regdst = 2'b01;
        if (k == K_LW) s.sig.datasrc = 2'b01;
        push_step(s);
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b001101, 6'b001111, 6'b100011,
                          6'b101011, 6'b000100, 6'b000010, 6'b000011};
    endfunction

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            K_JR:   begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 6'b000000;
                    while (fn inside {6'b100001, 6'b100011, 6'b001000}) fn = 6'($urandom);
                end else begin
                    op = 6'($urandom);
                    while (legal_op(op)) op = 6'($urandom);
                end
            end
        endcase
    endtask

    // Drives one instruction cycle by cycle, queueing each expected cycle.
    task automatic run_instr(input kind_e k, input int fw, input int mw, input logic z,
                             input int max_steps);
        logic [5:0] op, fn;
        encode(k, op, fn);
        trace.delete();
        build(k, fw, mw, z);
        for (int i = 0; i < trace.size() && i < max_steps; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin OpCode = op; Funct = fn; end
            mem_ready = trace[i].mr;
            Zero = trace[i].z;
            scb.push_back(trace[i]);
        end
    endtask

    task automatic ill_op(input logic [5:0] op);
        trace.delete();
        build(K_ILL, 0, 0, 1'b0);
        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin OpCode = op; Funct = 6'b000000; end
            mem_ready = trace[i].mr;
            Zero = trace[i].z;
            scb.push_back(trace[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        sig_t zero_sig;
        zero_sig = '0;
        #2 reset = 1'b0;
        #2;
        check("reset_outputs", 64'(dut_sig()), 64'(zero_sig));
        check("reset_retired", 64'(retired), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        run_instr(K_ADDU, 0, 0, 1'b0, 1000);
        run_instr(K_LW, 0, 3, 1'b0, 1000);
        run_instr(K_BEQ, 0, 0, 1'b1, 1000);
        run_instr(K_BEQ, 0, 0, 1'b0, 1000);
        run_instr(K_JAL, 0, 0, 1'b0, 1000);
        ill_op(6'b111111);
        run_instr(K_SW, 2, 1, 1'b0, 1000);

        // Random mix
        for (int n = 0; n < 300; n++) begin
            run_instr(kind_e'($urandom_range(0, 10)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom), 1000);
        end
        if (model_ret == 0) run_instr(K_J, 0, 0, 1'b0, 1000);

        // Abort a store while it waits in MEM.
        run_instr(K_SW, 0, 5, 1'b0, 4);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        check("pre_reset_memwrite", 64'(MemWrite), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_outputs", 64'(dut_sig()), 64'(zero_sig));
        check("abort_retired", 64'(retired), 64'd0);
        @(posedge clk);
        #1;
        check("abort_held_outputs", 64'(dut_sig()), 64'(zero_sig));
        check("abort_held_retired", 64'(retired), 64'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        scb.delete();
        model_ret = 0;
        reset = 1'b1;
        mon_en = 1'b1;

        // Count up through all-ones and wrap.
        for (int n = 0; n < (1 << RW) + 1; n++) run_instr(K_J, 0, 0, 1'b0, 1000);
        run_instr(K_ADDU, 0, 0, 1'b0, 1000);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(scb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
